// File: rtl/bp_train_tracker.sv
// In-order tracker of issued branch predictions. It pairs each resolution with the oldest
// outstanding prediction and drives a one-cycle training pulse back to the gshare predictor.
module bp_train_tracker #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [HIST_W-1:0]        pred_history,
  input  logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     train_valid,
  output logic                     train_taken,
  output logic                     train_mispredicted,
  output logic [PC_W-1:0]          train_pc,
  output logic [HIST_W-1:0]        train_history,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resolve_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);

  // Pointers carry one extra wrap bit so a full queue and an empty queue differ.
  logic [PTR_W:0]      r_head;
  logic [PTR_W:0]      r_tail;
  logic [PC_W-1:0]     r_pc_mem    [DEPTH];
  logic [HIST_W-1:0]   r_hist_mem  [DEPTH];
  logic                r_taken_mem [DEPTH];

  logic                r_train_valid;
  logic                r_train_taken;
  logic                r_train_mis;
  logic [PC_W-1:0]     r_train_pc;
  logic [HIST_W-1:0]   r_train_hist;
  logic                r_resolve_err;

  logic [PTR_W:0]      w_count;
  logic [PTR_W-1:0]    w_head_idx;
  logic [PTR_W-1:0]    w_tail_idx;
  logic                w_empty;
  logic                w_enq;
  logic                w_res;
  logic                w_mis;
  logic                w_enq_keep;

  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];
  assign w_empty    = (w_count == '0);
  assign pred_ready = (w_count != FULL_CNT);
  assign w_enq      = pred_valid & pred_ready;
  assign w_res      = resolve_valid & ~w_empty;
  assign w_mis      = r_taken_mem[w_head_idx] ^ resolve_taken;
  // A mispredicting resolve makes any same-cycle prediction wrong-path, so it is not kept.
  assign w_enq_keep = w_enq & ~flush & ~(w_res & w_mis);

  // NOTE: entry storage has no reset; head/tail decide what is valid, so stale data is never read.
  always_ff @(posedge clk) begin
    if (w_enq_keep) begin
      r_pc_mem[w_tail_idx]    <= pred_pc;
      r_hist_mem[w_tail_idx]  <= pred_history;
      r_taken_mem[w_tail_idx] <= pred_taken;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_train_valid <= 1'b0;
      r_train_taken <= 1'b0;
      r_train_mis   <= 1'b0;
      r_train_pc    <= '0;
      r_train_hist  <= '0;
      r_resolve_err <= 1'b0;
    end else begin
      r_train_valid <= 1'b0;
      r_resolve_err <= 1'b0;
      if (flush) begin
        r_head <= r_tail;
      end else begin
        r_resolve_err <= resolve_valid & w_empty;
        if (w_res) begin
          r_train_valid <= 1'b1;
          r_train_taken <= resolve_taken;
          r_train_mis   <= w_mis;
          r_train_pc    <= r_pc_mem[w_head_idx];
          r_train_hist  <= r_hist_mem[w_head_idx];
          r_head        <= w_mis ? r_tail : r_head + PTR_ONE;
        end
        if (w_enq_keep) begin
          r_tail <= r_tail + PTR_ONE;
        end
      end
    end
  end

  assign train_valid        = r_train_valid;
  assign train_taken        = r_train_taken;
  assign train_mispredicted = r_train_mis;
  assign train_pc           = r_train_pc;
  assign train_history      = r_train_hist;
  assign count              = w_count;
  assign resolve_err        = r_resolve_err;

endmodule

// File: tb/tb_bp_train_tracker.sv
// Directed self-checking bench for bp_train_tracker: reset, correct and mispredicted
// training, full queue with pointer wrap, empty resolve and flush priority.
module tb_bp_train_tracker;

  localparam int PC_W   = 7;
  localparam int HIST_W = 7;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              areset_n;
  logic              pred_valid;
  logic              pred_ready;
  logic [PC_W-1:0]   pred_pc;
  logic [HIST_W-1:0] pred_history;
  logic              pred_taken;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              flush;
  logic              train_valid;
  logic              train_taken;
  logic              train_mispredicted;
  logic [PC_W-1:0]   train_pc;
  logic [HIST_W-1:0] train_history;
  logic [3:0]        count;
  logic              resolve_err;

  int checks   = 0;
  int failures = 0;

  bp_train_tracker #(.PC_W(PC_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .areset_n           (areset_n),
    .pred_valid         (pred_valid),
    .pred_ready         (pred_ready),
    .pred_pc            (pred_pc),
    .pred_history       (pred_history),
    .pred_taken         (pred_taken),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .flush              (flush),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_pc           (train_pc),
    .train_history      (train_history),
    .count              (count),
    .resolve_err        (resolve_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid    = 1'b0;
    pred_pc       = '0;
    pred_history  = '0;
    pred_taken    = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic set_pred(input logic [6:0] pc, input logic [6:0] hist, input logic tk);
    pred_valid   = 1'b1;
    pred_pc      = pc;
    pred_history = hist;
    pred_taken   = tk;
  endtask

  task automatic set_resolve(input logic tk);
    resolve_valid = 1'b1;
    resolve_taken = tk;
  endtask

  task automatic check_train(input string tag, input logic [6:0] pc, input logic [6:0] hist,
                             input logic tk, input logic mis);
    check({tag, "_valid"}, 32'(train_valid), 32'(1));
    check({tag, "_pc"},    32'(train_pc), 32'(pc));
    check({tag, "_hist"},  32'(train_history), 32'(hist));
    check({tag, "_taken"}, 32'(train_taken), 32'(tk));
    check({tag, "_mis"},   32'(train_mispredicted), 32'(mis));
  endtask

  initial begin
    idle();
    areset_n = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'(0));
    check("rst_train_valid", 32'(train_valid), 32'(0));
    check("rst_train_pc", 32'(train_pc), 32'(0));
    check("rst_err", 32'(resolve_err), 32'(0));
    check("rst_ready", 32'(pred_ready), 32'(1));
    @(negedge clk);
    areset_n = 1'b1;
    cycle();

    // Correct prediction trains with mispredicted=0.
    set_pred(7'h12, 7'h05, 1'b1);
    cycle();
    check("t2_count1", 32'(count), 32'(1));
    idle();
    set_resolve(1'b1);
    cycle();
    check_train("t2", 7'h12, 7'h05, 1'b1, 1'b0);
    check("t2_count0", 32'(count), 32'(0));
    idle();
    cycle();
    check("t2_pulse", 32'(train_valid), 32'(0));
    check("t2_hold_pc", 32'(train_pc), 32'(7'h12));

    // Mispredict clears the queue including a same-cycle enqueue.
    set_pred(7'h40, 7'h11, 1'b0); cycle();
    set_pred(7'h41, 7'h12, 1'b1); cycle();
    set_pred(7'h42, 7'h13, 1'b1); cycle();
    check("t3_count3", 32'(count), 32'(3));
    set_pred(7'h43, 7'h14, 1'b1);
    set_resolve(1'b1);
    cycle();
    check_train("t3", 7'h40, 7'h11, 1'b1, 1'b1);
    check("t3_count0", 32'(count), 32'(0));
    idle();
    cycle();
    check("t3_count_after", 32'(count), 32'(0));
    check("t3_pulse", 32'(train_valid), 32'(0));

    // Fill to full, drop a 9th, then drain and refill across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      set_pred(7'(8'h20 + i), 7'(8'h60 + i), 1'(i));
      cycle();
    end
    check("t4_full_count", 32'(count), 32'(8));
    check("t4_full_ready", 32'(pred_ready), 32'(0));
    set_pred(7'h7F, 7'h7F, 1'b1);
    cycle();
    check("t4_drop_count", 32'(count), 32'(8));
    idle();
    set_resolve(1'b0);
    cycle();
    check_train("t4_old0", 7'h20, 7'h60, 1'b0, 1'b0);
    check("t4_count7", 32'(count), 32'(7));
    for (int i = 1; i < 8; i++) begin
      idle();
      set_resolve(1'(i));
      set_pred(7'(8'h50 + i - 1), 7'(8'h70 + i - 1), 1'((i - 1) >> 1));
      cycle();
      check_train("t4_old", 7'(8'h20 + i), 7'(8'h60 + i), 1'(i), 1'b0);
      check("t4_mid_count", 32'(count), 32'(7));
    end
    idle();
    set_pred(7'h57, 7'h77, 1'b1);
    cycle();
    check("t4_refill_count", 32'(count), 32'(8));
    check("t4_refill_ready", 32'(pred_ready), 32'(0));
    for (int j = 0; j < 8; j++) begin
      idle();
      set_resolve(1'(j >> 1));
      cycle();
      check_train("t4_new", 7'(8'h50 + j), 7'(8'h70 + j), 1'(j >> 1), 1'b0);
    end
    idle();
    check("t4_drained", 32'(count), 32'(0));

    // Resolve on an empty queue raises a one-cycle error and no training.
    set_resolve(1'b1);
    cycle();
    check("t5_err", 32'(resolve_err), 32'(1));
    check("t5_train_valid", 32'(train_valid), 32'(0));
    check("t5_count", 32'(count), 32'(0));
    idle();
    cycle();
    check("t5_err_pulse", 32'(resolve_err), 32'(0));

    // Flush wins over a resolve and an enqueue in the same cycle.
    set_pred(7'h10, 7'h01, 1'b1); cycle();
    set_pred(7'h11, 7'h02, 1'b0); cycle();
    check("t6_count2", 32'(count), 32'(2));
    set_pred(7'h15, 7'h03, 1'b1);
    set_resolve(1'b0);
    flush = 1'b1;
    cycle();
    check("t6_count", 32'(count), 32'(0));
    check("t6_train_valid", 32'(train_valid), 32'(0));
    check("t6_err", 32'(resolve_err), 32'(0));
    check("t6_hold_pc", 32'(train_pc), 32'(7'h57));
    idle();
    cycle();
    check("t6_count_after", 32'(count), 32'(0));

    // Asynchronous reset in the middle of traffic.
    set_pred(7'h33, 7'h44, 1'b1); cycle();
    set_pred(7'h34, 7'h45, 1'b0);
    set_resolve(1'b1);
    cycle();
    check("t1_pre_valid", 32'(train_valid), 32'(1));
    check("t1_pre_count", 32'(count), 32'(1));
    #2;
    areset_n = 1'b0;
    #1;
    check("t1_count", 32'(count), 32'(0));
    check("t1_train_valid", 32'(train_valid), 32'(0));
    check("t1_ready", 32'(pred_ready), 32'(1));
    check("t1_train_pc", 32'(train_pc), 32'(0));
    idle();
    @(negedge clk);
    areset_n = 1'b1;
    cycle();
    check("t1_after_count", 32'(count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
